// File: rtl/rr_sel_arbiter_4ch_if.sv
// Handshake bundle between the round-robin arbiter and its requesters/downstream.
// The master side is the arbiter; the slave side drives requests and ready.
interface rr_sel_arbiter_4ch_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       out_valid;
    logic [3:0] ack;
    logic       busy;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output ack,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  ack,
        input  busy
    );
endinterface

// File: rtl/rr_sel_arbiter_4ch.sv
// Four-channel round-robin arbiter steering the mux_4to1 select, with a bounded
// burst per grant and a valid/ready handshake toward the downstream consumer.
module rr_sel_arbiter_4ch #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_sel_arbiter_4ch_if.master bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;
    logic             busy;
    logic             out_valid;
    logic             xfer;

    // Search starts at ptr and wraps, so the channel granted last is tried last.
    always_comb begin
        pick  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign busy      = rst_n && (state == GRANT);
    assign out_valid = busy && bus.req[sel];
    assign xfer      = out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            grant <= 4'b0000;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        sel   <= pick;
                        grant <= 4'b0001 << pick;
                        ptr   <= pick + 2'd1;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    // A completed transfer at the burst limit wins over a withdrawn request.
                    if (xfer) begin
                        if (cnt == LAST_CNT) begin
                            state <= IDLE;
                            grant <= 4'b0000;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (!bus.req[sel]) begin
                        state <= IDLE;
                        grant <= 4'b0000;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.sel       = sel;
    assign bus.grant     = grant;
    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.ack       = xfer ? grant : 4'b0000;

endmodule
